// File: rtl/bsg_chip_link_prbs_tester.sv
// PRBS-15 generator/checker for one 16-bit link channel, with transparent passthrough when idle.
// Optional error injection on the generator is built when BSG_CHIP_LINK_PRBS_INJECT_EN is defined.
module bsg_chip_link_prbs_tester #(
  parameter int          width_p      = 16,
  parameter logic [14:0] seed_p       = 15'h7FFF,
  parameter int          lock_count_p = 4,
  parameter int          loss_count_p = 8,
  parameter int          cnt_width_p  = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
`ifdef BSG_CHIP_LINK_PRBS_INJECT_EN
  input  logic                   inject_err_i,
`endif
  input  logic                   test_en_i,
  input  logic                   clear_i,
  input  logic [width_p-1:0]     core_data_i,
  input  logic                   core_v_i,
  output logic [width_p-1:0]     pad_data_o,
  output logic                   pad_v_o,
  input  logic [width_p-1:0]     pad_data_i,
  input  logic                   pad_v_i,
  output logic [width_p-1:0]     core_data_o,
  output logic                   core_v_o,
  output logic                   locked_o,
  output logic [cnt_width_p-1:0] word_cnt_o,
  output logic [cnt_width_p-1:0] err_cnt_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEED = 2'd1, ACQ = 2'd2, LOCKED = 2'd3} state_e;

  // 16 serial steps of x^15+x^14+1, first step lands in bit 15
  function automatic logic [15:0] prbs_word(input logic [14:0] s);
    logic [14:0] st;
    logic        b;
    logic [15:0] w;
    st = s;
    w  = 16'h0000;
    for (int i = 15; i >= 0; i--) begin
      b    = st[14] ^ st[13];
      w[i] = b;
      st   = {st[13:0], b};
    end
    return w;
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  logic [14:0]        gen_r;
  logic [15:0]        gen_word_r;
  logic               test_r;
  logic [15:0]        gen_next_s;
  logic               inject_rise_s;
  logic [width_p-1:0] gen_ext_s;

`ifdef BSG_CHIP_LINK_PRBS_INJECT_EN
  logic inject_q_r;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) inject_q_r <= 1'b0;
    else         inject_q_r <= inject_err_i;
  end
  assign inject_rise_s = inject_err_i & ~inject_q_r;
`else
  assign inject_rise_s = 1'b0;
`endif

  assign gen_next_s = prbs_word(gen_r);

  // injection corrupts only the outgoing copy; gen_r keeps the clean sequence
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      gen_r      <= seed_p;
      gen_word_r <= 16'h0000;
      test_r     <= 1'b0;
    end else if (test_en_i) begin
      gen_r      <= gen_next_s[14:0];
      gen_word_r <= gen_next_s ^ {15'h0000, inject_rise_s};
      test_r     <= 1'b1;
    end else begin
      gen_r      <= seed_p;
      gen_word_r <= 16'h0000;
      test_r     <= 1'b0;
    end
  end

  always_comb begin
    gen_ext_s       = '0;
    gen_ext_s[15:0] = gen_word_r;
    if (test_en_i) begin
      pad_data_o  = gen_ext_s;
      pad_v_o     = test_r;
      core_data_o = '0;
      core_v_o    = 1'b0;
    end else begin
      pad_data_o  = core_data_i;
      pad_v_o     = core_v_i;
      core_data_o = pad_data_i;
      core_v_o    = pad_v_i;
    end
  end

  state_e                 state_r, state_nxt_s;
  logic [14:0]            chk_r, chk_nxt_s;
  logic [7:0]             match_r, match_nxt_s, miss_r, miss_nxt_s;
  logic [cnt_width_p-1:0] word_r, word_nxt_s, err_r, err_nxt_s, word_sat_s, err_sat_s;
  logic [cnt_width_p:0]   word_sum_s, err_sum_s, pop_ext_s;
  logic                   locked_r;
  logic [15:0]            rx_s, pred_s, diff_s;
  logic                   hit_s;

  assign rx_s   = pad_data_i[15:0];
  assign pred_s = prbs_word(chk_r);
  assign diff_s = rx_s ^ pred_s;
  assign hit_s  = (diff_s == 16'h0000);

  // one extra bit catches overflow so the sum can clamp to all-ones
  always_comb begin
    pop_ext_s      = '0;
    pop_ext_s[4:0] = popcount16(diff_s);
    word_sum_s     = {1'b0, word_r} + {{cnt_width_p{1'b0}}, 1'b1};
    err_sum_s      = {1'b0, err_r} + pop_ext_s;
    word_sat_s     = word_sum_s[cnt_width_p] ? '1 : word_sum_s[cnt_width_p-1:0];
    err_sat_s      = err_sum_s[cnt_width_p] ? '1 : err_sum_s[cnt_width_p-1:0];
  end

  always_comb begin
    state_nxt_s = state_r;
    chk_nxt_s   = chk_r;
    match_nxt_s = match_r;
    miss_nxt_s  = miss_r;
    word_nxt_s  = word_r;
    err_nxt_s   = err_r;
    if (!test_en_i) begin
      state_nxt_s = IDLE;
      if (clear_i) begin
        word_nxt_s = '0;
        err_nxt_s  = '0;
      end else begin
        word_nxt_s = word_r;
        err_nxt_s  = err_r;
      end
    end else if (clear_i) begin
      state_nxt_s = SEED;
      match_nxt_s = 8'd0;
      miss_nxt_s  = 8'd0;
      word_nxt_s  = '0;
      err_nxt_s   = '0;
    end else if (state_r == IDLE) begin
      state_nxt_s = SEED;
    end else if (pad_v_i) begin
      case (state_r)
        SEED: begin
          chk_nxt_s   = rx_s[14:0];
          match_nxt_s = 8'd0;
          state_nxt_s = ACQ;
        end
        ACQ: begin
          chk_nxt_s = pred_s[14:0];
          if (hit_s) begin
            match_nxt_s = match_r + 8'd1;
            if (match_r + 8'd1 == 8'(lock_count_p)) begin
              state_nxt_s = LOCKED;
              miss_nxt_s  = 8'd0;
            end else begin
              state_nxt_s = ACQ;
            end
          end else begin
            state_nxt_s = SEED;
          end
        end
        LOCKED: begin
          chk_nxt_s  = pred_s[14:0];
          word_nxt_s = word_sat_s;
          err_nxt_s  = err_sat_s;
          if (hit_s) begin
            miss_nxt_s = 8'd0;
          end else begin
            miss_nxt_s = miss_r + 8'd1;
            if (miss_r + 8'd1 == 8'(loss_count_p)) state_nxt_s = SEED;
            else                                   state_nxt_s = LOCKED;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r  <= IDLE;
      chk_r    <= seed_p;
      match_r  <= 8'd0;
      miss_r   <= 8'd0;
      word_r   <= '0;
      err_r    <= '0;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      chk_r    <= chk_nxt_s;
      match_r  <= match_nxt_s;
      miss_r   <= miss_nxt_s;
      word_r   <= word_nxt_s;
      err_r    <= err_nxt_s;
      locked_r <= (state_nxt_s == LOCKED);
    end
  end

  assign locked_o   = locked_r;
  assign word_cnt_o = word_r;
  assign err_cnt_o  = err_r;

endmodule

// File: tb/tb_bsg_chip_link_prbs_tester.sv
// Randomized bench for bsg_chip_link_prbs_tester: expected PRBS words come from a precomputed
// bit stream, and checker lock/counter behaviour from a rule-level reference model.
module tb_bsg_chip_link_prbs_tester;

  localparam int NW   = 4096;
  localparam int LOCK = 4;
  localparam int LOSS = 8;

  logic        clk = 1'b0;
  logic        rst, test_en, clear_i, core_v_i, pad_v_i;
  logic        pad_v_o, core_v_o, locked_o;
  logic [15:0] core_data_i, pad_data_i, pad_data_o, core_data_o;
  logic [7:0]  word_cnt_o, err_cnt_o;
  logic        inject_err;

  always #5 clk = ~clk;

  bsg_chip_link_prbs_tester #(
    .width_p(16), .seed_p(15'h7FFF), .lock_count_p(4), .loss_count_p(8), .cnt_width_p(8)
  ) dut (
    .clk_i(clk),
    .reset_i(rst),
`ifdef BSG_CHIP_LINK_PRBS_INJECT_EN
    .inject_err_i(inject_err),
`endif
    .test_en_i(test_en),
    .clear_i(clear_i),
    .core_data_i(core_data_i),
    .core_v_i(core_v_i),
    .pad_data_o(pad_data_o),
    .pad_v_o(pad_v_o),
    .pad_data_i(pad_data_i),
    .pad_v_i(pad_v_i),
    .core_data_o(core_data_o),
    .core_v_o(core_v_o),
    .locked_o(locked_o),
    .word_cnt_o(word_cnt_o),
    .err_cnt_o(err_cnt_o)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          xs [15+16*NW];
  logic [15:0] txw [NW];
  // model: 0 idle, 1 seed, 2 acquire, 3 locked
  int          mst, mmatch, mmiss, mword, merr, ridx, gidx;
  bit          gvalid;
  logic [15:0] gexp;

  task automatic build_stream();
    for (int i = 0; i < 15; i++) xs[i] = 1'b1;
    for (int n = 15; n < 15 + 16 * NW; n++) xs[n] = xs[n-15] ^ xs[n-14];
    for (int j = 0; j < NW; j++)
      for (int t = 0; t < 16; t++) txw[j][15-t] = xs[15 + 16 * j + t];
  endtask

  function automatic logic [16:0] model_vec();
    return {(mst == 3), 8'(mword), 8'(merr)};
  endfunction

  task automatic tick(input bit pv, input logic [15:0] mask, input bit clr);
    int pop;
    pad_v_i    = pv;
    pad_data_i = pv ? (txw[ridx] ^ mask) : 16'($urandom);
    clear_i    = clr;
    @(posedge clk);
    pop = $countones(mask);
    if (!test_en) begin
      mst = 0;
      if (clr) begin mword = 0; merr = 0; end
    end else if (clr) begin
      mword = 0; merr = 0; mst = 1;
    end else if (mst == 0) begin
      mst = 1;
    end else if (pv) begin
      if (mst == 1) begin
        mst = 2; mmatch = 0;
      end else if (mst == 2) begin
        if (mask == 16'h0000) begin
          mmatch++;
          if (mmatch == LOCK) begin mst = 3; mmiss = 0; end
        end else mst = 1;
      end else begin
        mword = (mword + 1 > 255) ? 255 : mword + 1;
        merr  = (merr + pop > 255) ? 255 : merr + pop;
        if (mask != 16'h0000) begin
          mmiss++;
          if (mmiss == LOSS) mst = 1;
        end else mmiss = 0;
      end
    end
    if (pv) ridx++;
    if (test_en) begin gexp = txw[gidx]; gidx++; gvalid = 1'b1; end
    else begin gidx = 0; gvalid = 1'b0; end
    #1;
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; test_en = 1'b0; clear_i = 1'b0; inject_err = 1'b0;
    core_v_i = 1'b1; pad_v_i = 1'b1; core_data_i = 16'h0000; pad_data_i = 16'h0000;
    #2;
    n_tests++;
    if ({locked_o, word_cnt_o, err_cnt_o, pad_v_o, core_v_o} !== {1'b0, 8'h00, 8'h00, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL reset_values got %h exp %h",
        {locked_o, word_cnt_o, err_cnt_o, pad_v_o, core_v_o}, {1'b0, 8'h00, 8'h00, 1'b1, 1'b1});
    end
    test_en = 1'b1; #1;
    n_tests++;
    if ({pad_v_o, core_v_o, core_data_o} !== {1'b0, 1'b0, 16'h0000}) begin
      n_fail++; $display("FAIL reset_testmode_valids got %h exp %h", {pad_v_o, core_v_o, core_data_o}, 18'h0);
    end
    test_en = 1'b0; core_v_i = 1'b0; pad_v_i = 1'b0;
    mst = 0; mmatch = 0; mmiss = 0; mword = 0; merr = 0; ridx = 0; gidx = 0; gvalid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 6; i++) begin
      core_data_i = (i == 0) ? 16'hA5C3 : 16'($urandom);
      core_v_i    = (i == 0) ? 1'b1 : 1'($urandom);
      pad_data_i  = 16'($urandom);
      pad_v_i     = (i == 0) ? 1'b1 : 1'($urandom);
      #1;
      n_tests++;
      if ({pad_data_o, pad_v_o, core_data_o, core_v_o} !== {core_data_i, core_v_i, pad_data_i, pad_v_i}) begin
        n_fail++; $display("FAIL passthrough_%0d got %h exp %h", i,
          {pad_data_o, pad_v_o, core_data_o, core_v_o}, {core_data_i, core_v_i, pad_data_i, pad_v_i});
      end
    end
    core_v_i = 1'b0; pad_v_i = 1'b0;
  endtask

  task automatic test_generator();
    test_en = 1'b1;
    tick(1'b0, 16'h0000, 1'b0);
    n_tests++;
    if ({pad_data_o, pad_v_o} !== {16'h0002, 1'b1}) begin
      n_fail++; $display("FAIL gen_first_word got %h exp %h", {pad_data_o, pad_v_o}, {16'h0002, 1'b1});
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'($urandom_range(0, 1)), 16'h0000, 1'b0);
      n_tests++;
      if ({pad_data_o, pad_v_o, core_data_o, core_v_o} !== {gexp, 1'b1, 16'h0000, 1'b0}) begin
        n_fail++; $display("FAIL gen_word_%0d got %h exp %h", i,
          {pad_data_o, pad_v_o, core_data_o, core_v_o}, {gexp, 1'b1, 16'h0000, 1'b0});
      end
    end
    test_en = 1'b0; core_data_i = 16'h1234;
    tick(1'b0, 16'h0000, 1'b0);
    n_tests++;
    if ({pad_data_o, locked_o} !== {16'h1234, 1'b0}) begin
      n_fail++; $display("FAIL gen_exit got %h exp %h", {pad_data_o, locked_o}, {16'h1234, 1'b0});
    end
    test_en = 1'b1;
    tick(1'b0, 16'h0000, 1'b0);
    n_tests++;
    if (pad_data_o !== 16'h0002) begin
      n_fail++; $display("FAIL gen_reload got %h exp %h", pad_data_o, 16'h0002);
    end
  endtask

  task automatic test_lock();
    tick(1'b0, 16'h0000, 1'b1);
    n_tests++;
    if ({locked_o, word_cnt_o, err_cnt_o} !== 17'h0) begin
      n_fail++; $display("FAIL lock_clear got %h exp %h", {locked_o, word_cnt_o, err_cnt_o}, 17'h0);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 16'h0000, 1'b0);
      n_tests++;
      if ({locked_o, word_cnt_o, err_cnt_o} !== {(i == 4), 8'h00, 8'h00}) begin
        n_fail++; $display("FAIL lock_acquire_%0d got %h exp %h", i,
          {locked_o, word_cnt_o, err_cnt_o}, {(i == 4), 8'h00, 8'h00});
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 16'h0000, 1'b0);
      n_tests++;
      if ({locked_o, word_cnt_o, err_cnt_o} !== {1'b1, 8'(i + 1), 8'h00}) begin
        n_fail++; $display("FAIL lock_word_count_%0d got %h exp %h", i,
          {locked_o, word_cnt_o, err_cnt_o}, {1'b1, 8'(i + 1), 8'h00});
      end
    end
  endtask

  task automatic test_errors();
    int e0;
    e0 = merr;
    tick(1'b1, 16'h0101, 1'b0);
    n_tests++;
    if ({locked_o, err_cnt_o} !== {1'b1, 8'(e0 + 2)}) begin
      n_fail++; $display("FAIL err_two_bits got %h exp %h", {locked_o, err_cnt_o}, {1'b1, 8'(e0 + 2)});
    end
    tick(1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 16'hFFFF, 1'b0);
      n_tests++;
      if (locked_o !== (i < 7) || {locked_o, word_cnt_o, err_cnt_o} !== model_vec()) begin
        n_fail++; $display("FAIL err_loss_%0d got %h exp %h", i, {locked_o, word_cnt_o, err_cnt_o}, model_vec());
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 16'h0000, 1'b0);
      n_tests++;
      if (locked_o !== (i == 4)) begin
        n_fail++; $display("FAIL err_relock_%0d got %b exp %b", i, locked_o, (i == 4));
      end
    end
  endtask

  task automatic test_random();
    bit          pv, clr;
    logic [15:0] mask;
    for (int i = 0; i < 300; i++) begin
      pv   = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 49) == 0);
      mask = 16'h0000;
      if (mst >= 2 && $urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 2))
          0:       mask = 16'h0001 << $urandom_range(0, 15);
          1:       mask = 16'($urandom) | 16'h8000;
          default: mask = 16'hFFFF;
        endcase
      end
      tick(pv, mask, clr);
      n_tests++;
      if ({locked_o, word_cnt_o, err_cnt_o, pad_data_o} !== {model_vec(), gexp}) begin
        n_fail++; $display("FAIL random_%0d got %h exp %h", i,
          {locked_o, word_cnt_o, err_cnt_o, pad_data_o}, {model_vec(), gexp});
      end
    end
  endtask

  task automatic test_saturation();
    int r;
    tick(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 16'h0000, 1'b0);
    while (merr < 238) begin
      tick(1'b1, 16'hFFFF, 1'b0);
      tick(1'b1, 16'h0000, 1'b0);
    end
    r = 254 - merr;
    if (r > 0) tick(1'b1, 16'((17'd1 << r) - 17'd1), 1'b0);
    n_tests++;
    if ({locked_o, err_cnt_o} !== {1'b1, 8'hFE}) begin
      n_fail++; $display("FAIL sat_err_fe got %h exp %h", {locked_o, err_cnt_o}, {1'b1, 8'hFE});
    end
    tick(1'b1, 16'h0007, 1'b0);
    n_tests++;
    if ({locked_o, err_cnt_o} !== {1'b1, 8'hFF}) begin
      n_fail++; $display("FAIL sat_err_clamp got %h exp %h", {locked_o, err_cnt_o}, {1'b1, 8'hFF});
    end
    for (int i = 0; i < 260; i++) tick(1'b1, 16'h0000, 1'b0);
    n_tests++;
    if ({locked_o, word_cnt_o, err_cnt_o} !== {1'b1, 8'hFF, 8'hFF}) begin
      n_fail++; $display("FAIL sat_word_clamp got %h exp %h", {locked_o, word_cnt_o, err_cnt_o}, {1'b1, 8'hFF, 8'hFF});
    end
    tick(1'b1, 16'h0003, 1'b1);
    n_tests++;
    if ({locked_o, word_cnt_o, err_cnt_o} !== 17'h0) begin
      n_fail++; $display("FAIL sat_clear_priority got %h exp %h", {locked_o, word_cnt_o, err_cnt_o}, 17'h0);
    end
    tick(1'b1, 16'h0000, 1'b0);
    n_tests++;
    if ({locked_o, word_cnt_o, err_cnt_o} !== model_vec() || mst != 2) begin
      n_fail++; $display("FAIL sat_after_clear got %h exp %h", {locked_o, word_cnt_o, err_cnt_o}, model_vec());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) tick(1'b1, 16'h0000, 1'b0);
    n_tests++;
    if (locked_o !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre_lock got %b exp %b", locked_o, 1'b1);
    end
    #3; rst = 1'b1; #1;
    n_tests++;
    if ({locked_o, word_cnt_o, err_cnt_o, pad_v_o} !== 18'h0) begin
      n_fail++; $display("FAIL midreset_async got %h exp %h", {locked_o, word_cnt_o, err_cnt_o, pad_v_o}, 18'h0);
    end
    mst = 0; mmatch = 0; mmiss = 0; mword = 0; merr = 0; gidx = 0; gvalid = 1'b0;
    #2; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 16'h0000, 1'b0);
      n_tests++;
      if ({locked_o, word_cnt_o, err_cnt_o, pad_data_o} !== {model_vec(), gexp}) begin
        n_fail++; $display("FAIL midreset_recover_%0d got %h exp %h", i,
          {locked_o, word_cnt_o, err_cnt_o, pad_data_o}, {model_vec(), gexp});
      end
    end
  endtask

`ifdef BSG_CHIP_LINK_PRBS_INJECT_EN
  task automatic test_inject();
    int ndiff;
    ndiff = 0;
    for (int i = 0; i < 8; i++) begin
      inject_err = (i >= 2 && i < 5);
      tick(1'b0, 16'h0000, 1'b0);
      if (pad_data_o !== gexp) begin
        ndiff++;
        if ((pad_data_o ^ gexp) !== 16'h0001) ndiff += 100;
      end
    end
    inject_err = 1'b0;
    n_tests++;
    if (ndiff != 1) begin
      n_fail++; $display("FAIL inject_single_flip got %0d exp %0d", ndiff, 1);
    end
  endtask
`endif

  initial begin
    build_stream();
    test_reset();
    test_passthrough();
    test_generator();
    test_lock();
    test_errors();
    test_random();
    test_saturation();
    test_reset_mid();
`ifdef BSG_CHIP_LINK_PRBS_INJECT_EN
    test_inject();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_chip_link_prbs_tester.md
Name: bsg_chip_link_prbs_tester

Overview:
- Per-physical-link PRBS-15 generator and checker for one 16-bit link channel.
- Sits between the pad link hub and a bsg_chip_noc_io_link / bsg_chip_noc_mem_link port, in the link clock domain.
- In normal mode it passes traffic through unchanged. In test mode it drives PRBS words onto the pads and checks received words, for bring-up and margining of the IT/DL/DR links.
- Controlled and observed via bsg_tag-driven control bits.

Parameters:
- width_p, 16, channel data width; must be ≥16.
- seed_p, 15'h7FFF, generator reset/reload state; must be nonzero.
- lock_count_p, 4, consecutive matching words required to declare lock.
- loss_count_p, 8, consecutive mismatching words (while locked) that drop lock.
- cnt_width_p, 32, width of the word and error counters.

Ports:
- clk_i  in  1  link clock.
- reset_i  in  1  asynchronous, active-high reset.
- test_en_i  in  1  1 = PRBS test mode, 0 = passthrough.
- clear_i  in  1  synchronous clear of counters; checker returns to SEED.
- core_data_i  in  width_p  data from the link toward the pad.
- core_v_i  in  1  valid from the link toward the pad.
- pad_data_o  out  width_p  data to the pad.
- pad_v_o  out  1  valid to the pad.
- pad_data_i  in  width_p  data from the pad.
- pad_v_i  in  1  valid from the pad.
- core_data_o  out  width_p  data to the link.
- core_v_o  out  1  valid to the link.
- locked_o  out  1  checker is locked.
- word_cnt_o  out  cnt_width_p  received valid words checked while locked; saturating.
- err_cnt_o  out  cnt_width_p  bit errors while locked; saturating.

Behaviour:
- Clocking/reset: one clock (clk_i). reset_i is asynchronous and active-high. All flops reset asynchronously.
- Reset values:
  - gen state = seed_p; checker state = IDLE.
  - locked_o = 0; word_cnt_o = 0; err_cnt_o = 0.
  - pad_v_o = core_v_i & ~test_en_i (combinational path only); core_v_o = pad_v_i & ~test_en_i.
- Passthrough (test_en_i=0):
  - pad_data_o = core_data_i; pad_v_o = core_v_i; core_data_o = pad_data_i; core_v_o = pad_v_i.
  - Purely combinational, zero latency.
  - Gen state held at seed_p.
- Test mode (test_en_i=1):
  - core_v_o = 0 and core_data_o = 0, so link traffic is blocked.
  - pad_v_o = 1 and pad_data_o = gen word (registered), advancing every cycle.
- PRBS-15 (x^15+x^14+1), 16 serial steps per word, MSB first:
  - each step: b = s[14]^s[13]; s = {s[13:0], b}.
  - Word bit 15 is the first step. Bits above 15 (width_p>16) are zero.
- Generator sequencing:
  - First word in test mode (cycle after test_en_i rises) is the word from seed_p.
  - Falling test_en_i reloads seed_p.
- Checker FSM (advances only on pad_v_i=1 while test_en_i=1):
  - IDLE: on test_en_i → SEED.
  - SEED: load s_chk = pad_data_i[14:0]; match_cnt = 0 → ACQ.
  - ACQ: compare pad_data_i[15:0] to predicted word; s_chk always advances.
    - match: match_cnt++; at lock_count_p → LOCKED.
    - mismatch → SEED.
  - LOCKED: word_cnt += 1 and err_cnt += popcount(rx ^ predicted).
    - Both counters saturate at all-ones; an addition that overflows clamps.
    - Each mismatching word increments miss_cnt; a matching word clears it.
    - miss_cnt == loss_count_p → SEED; counters retained.
- locked_o = (state == LOCKED), registered.
- test_en_i low in any state → IDLE next cycle; locked_o = 0; counters retained.
- clear_i has priority over a same-cycle counter update:
  - counters = 0; non-IDLE states → SEED.
  - clear_i is honoured in IDLE too.
- pad_v_i = 0: no state or counter change.

Optional Feature:
- Macro: BSG_CHIP_LINK_PRBS_INJECT_EN.
- Defined:
  - Adds input inject_err_i (1 bit).
  - Its rising edge (registered edge detect) flips bit 0 of exactly one outgoing gen word.
  - Gen state is unaffected.
  - Ignored in passthrough.
- Undefined:
  - No port; no injection logic.

Test Plan:
- Passthrough: test_en_i=0, core_data_i=16'hA5C3, core_v_i=1 → pad_data_o=16'hA5C3, pad_v_o=1 same cycle; pad_v_i=1 → core_v_o=1.
- Generator: reset, seed 15'h7FFF, raise test_en_i → first pad_data_o=16'h0002 with pad_v_o=1; core_v_o=0 throughout.
- Lock: pad_data_i = pad_data_o delayed one cycle → locked_o=1 after 1 seed word + 4 matching words; err_cnt_o=0; word_cnt_o increments by 1 per cycle.
- Errors: while locked, XOR 16'h0101 onto one received word → err_cnt_o +2, locked_o stays 1. Then 8 consecutive words XOR 16'hFFFF → locked_o=0, relock after 5 good words.
- Saturation/clear: force err_cnt_o near all-ones (cnt_width_p=8, value 8'hFE), inject a 3-bit error → 8'hFF. Assert clear_i the same cycle as an error → counters 0, FSM SEED.
- Reset mid-test: assert reset_i asynchronously while LOCKED → locked_o, counters 0 immediately. With BSG_CHIP_LINK_PRBS_INJECT_EN, an inject pulse → exactly one word with err_cnt_o +1.
